// File: rtl/ntt_ctrl_pkg.sv
// Shared types and address helpers for the radix-2 NTT stage sequencer.
package ntt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Write-back trails the read by the synchronous RAM read plus the PE pipeline.
  localparam int unsigned RAM_RD_LAT = 1;

  function automatic int unsigned wb_lat(input int unsigned pe_lat);
    return pe_lat + RAM_RD_LAT;
  endfunction

  function automatic int unsigned bfly_half(input int unsigned s, input int unsigned log_n);
    return 32'd1 << (log_n - 1 - s);
  endfunction

  function automatic int unsigned bfly_top_addr(input int unsigned k, input int unsigned s,
                                                input int unsigned log_n);
    int unsigned half;
    half = bfly_half(s, log_n);
    return ((k >> (log_n - 1 - s)) << (log_n - s)) | (k & (half - 1));
  endfunction

  function automatic int unsigned bfly_tw(input int unsigned k, input int unsigned s,
                                          input int unsigned log_n);
    int unsigned half;
    half = bfly_half(s, log_n);
    return (k & (half - 1)) << s;
  endfunction

endpackage

// File: rtl/ntt_stage_ctrl_if.sv
// Handshake and memory-address bundle between the NTT sequencer and its surroundings.
interface ntt_stage_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int TW_W   = 3
);
  logic              start;
  logic              stall;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_top;
  logic [ADDR_W-1:0] rd_addr_bot;
  logic [TW_W-1:0]   tw_addr;
  logic [ADDR_W-1:0] stage_o;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_top;
  logic [ADDR_W-1:0] wr_addr_bot;

  modport master (
    input  start, stall,
    output busy, done, rd_en, rd_addr_top, rd_addr_bot, tw_addr, stage_o,
           wr_en, wr_addr_top, wr_addr_bot
  );

  modport slave (
    output start, stall,
    input  busy, done, rd_en, rd_addr_top, rd_addr_bot, tw_addr, stage_o,
           wr_en, wr_addr_top, wr_addr_bot
  );
endinterface

// File: rtl/ntt_ctrl_delay.sv
// Fixed-depth valid+data shift register with asynchronous active-low clear.
module ntt_ctrl_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W:0] pipe_d [DEPTH];
  logic [W:0] pipe_q [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign pipe_d[gi] = {in_valid, in_data};
      end else begin : g_body
        assign pipe_d[gi] = pipe_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign {out_valid, out_data} = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// In-place radix-2 NTT stage sequencer: issues one butterfly per cycle, delays write-back.
// Optional NTT_STAGE_CTRL_CYCCNT_EN adds a 32-bit busy-cycle counter output cyc_cnt.
module ntt_stage_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int LOG_N  = 4,
  parameter int PE_LAT = 2,
  parameter int ADDR_W = LOG_N,
  parameter int TW_W   = LOG_N - 1
) (
  input  logic              clk,
  input  logic              reset,
  ntt_stage_ctrl_if.master  bus
`ifdef NTT_STAGE_CTRL_CYCCNT_EN
  ,
  output logic [31:0]       cyc_cnt
`endif
);

  localparam int unsigned L   = wb_lat(PE_LAT);
  localparam int          NBF = 1 << (LOG_N - 1);
  localparam int          DCW = $clog2(L + 1);

  localparam logic [LOG_N-1:0]  K_LAST = LOG_N'(NBF - 1);
  localparam logic [ADDR_W-1:0] S_LAST = ADDR_W'(LOG_N - 1);
  localparam logic [DCW-1:0]    D_INIT = DCW'(L - 1);

  state_e            state_q, state_d;
  logic [LOG_N-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] s_q, s_d;
  logic [DCW-1:0]    drain_q, drain_d;

  logic              rd_en;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] top_addr;
  logic [ADDR_W-1:0] bot_addr;
  logic [TW_W-1:0]   tw_addr;
  logic [2*ADDR_W-1:0] wr_data;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    drain_d = drain_q;
    rd_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          k_d     = '0;
          s_d     = '0;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (!bus.stall) begin
          rd_en = 1'b1;
          if (k_q == K_LAST) begin
            k_d     = '0;
            drain_d = D_INIT;
            state_d = DRAIN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Wait out the read+PE latency so the next stage never reads stale data.
        busy = 1'b1;
        if (drain_q == '0) begin
          if (s_q == S_LAST) begin
            state_d = DONE;
            s_d     = '0;
            k_d     = '0;
          end else begin
            s_d     = s_q + 1'b1;
            state_d = ISSUE;
          end
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      drain_q <= drain_d;
    end
  end

  // Addresses are forced to zero outside ISSUE; during a stall k/s are frozen so they hold.
  always_comb begin
    top_addr = '0;
    bot_addr = '0;
    tw_addr  = '0;
    if (state_q == ISSUE) begin
      top_addr = ADDR_W'(bfly_top_addr(32'(k_q), 32'(s_q), LOG_N));
      bot_addr = top_addr + ADDR_W'(bfly_half(32'(s_q), LOG_N));
      tw_addr  = TW_W'(bfly_tw(32'(k_q), 32'(s_q), LOG_N));
    end
  end

  ntt_ctrl_delay #(
    .DEPTH (L),
    .W     (2 * ADDR_W)
  ) u_wb_delay (
    .clk       (clk),
    .rst_n     (reset),
    .in_valid  (rd_en),
    .in_data   ({top_addr, bot_addr}),
    .out_valid (bus.wr_en),
    .out_data  (wr_data)
  );

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.rd_en       = rd_en;
  assign bus.rd_addr_top = top_addr;
  assign bus.rd_addr_bot = bot_addr;
  assign bus.tw_addr     = tw_addr;
  assign bus.stage_o     = s_q;
  assign bus.wr_addr_top = wr_data[2*ADDR_W-1:ADDR_W];
  assign bus.wr_addr_bot = wr_data[ADDR_W-1:0];

`ifdef NTT_STAGE_CTRL_CYCCNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE && bus.start) begin
      cyc_d = '0;
    end else if (busy) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cyc_cnt = cyc_q;
`endif

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
Sequencer for the in-place radix-2 NTT butterfly datapath. Steps through all LOG_N stages and issues one butterfly per cycle. For each butterfly it produces dual-port memory read addresses (top/bot), a twiddle ROM index, and write-back addresses delayed to match the memory + butterfly PE pipeline. Sits between the top-level start/done handshake and the coefficient RAM / twiddle ROM / PE array.

Parameters:
LOG_N, 4, log2 of transform length; N = 2^LOG_N, N/2 butterflies per stage
PE_LAT, 2, butterfly PE pipeline depth in cycles (>=0)
ADDR_W, LOG_N, coefficient address width
TW_W, LOG_N-1, twiddle index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-low
start  in  1  begin a transform; sampled only in IDLE
stall  in  1  freeze issue (memory port contention); in-flight pipeline continues
busy  out  1  high in ISSUE and DRAIN
done  out  1  one-cycle pulse on completion
rd_en  out  1  read/butterfly issue strobe
rd_addr_top  out  ADDR_W  top operand address
rd_addr_bot  out  ADDR_W  bottom operand address
tw_addr  out  TW_W  twiddle index for issued butterfly
stage_o  out  ADDR_W  current stage index
wr_en  out  1  write-back strobe for PE results
wr_addr_top  out  ADDR_W  address for ntt_top result
wr_addr_bot  out  ADDR_W  address for ntt_bot result

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs, counters and delay pipeline cleared to 0.
- States: IDLE -> ISSUE (start=1) -> DRAIN (last butterfly of stage issued) -> ISSUE (drain done, stage<LOG_N-1) or DONE (drain done, last stage) -> IDLE (always, after 1 cycle).
- start while not in IDLE is ignored; no queuing.
- ISSUE: butterfly counter k (0..N/2-1), stage s. Per non-stalled cycle rd_en=1, then k increments. half = N>>(s+1), off = k & (half-1). rd_addr_top = ((k>>(LOG_N-1-s))<<(LOG_N-s)) | off; rd_addr_bot = rd_addr_top + half; tw_addr = off<<s (DIF ordering, TW_W bits, no overflow by construction).
- stall=1 in ISSUE: rd_en=0, k/s held, addresses held. stall is ignored in DRAIN/IDLE/DONE.
- Outputs are combinational from registered k/s; rd_en is combinational from state and stall.
- Write-back latency L = PE_LAT+1 (1-cycle synchronous RAM read). wr_en/wr_addr_* equal rd_en/rd_addr_* delayed exactly L cycles. Bubbles from stall propagate as wr_en=0.
- DRAIN: lasts exactly L cycles, counted by a down-counter; the last wr_en of a stage falls in the final DRAIN cycle. Next stage's first read follows, so there is no RAW hazard.
- DONE: done=1, busy=0 for one cycle. k, s, stage_o cleared.
- Unstalled total: busy high LOG_N*(N/2+L) cycles.
- Async reset mid-transform aborts immediately; no wr_en is emitted after reset release until a new start.

Optional Feature:
NTT_STAGE_CTRL_CYCCNT_EN
- Defined: adds output cyc_cnt (32 bits). Cleared on the start-accept edge, increments every busy cycle including stalls, holds after done until the next start. Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package ntt_ctrl_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), function bfly_top_addr(k,s), function bfly_tw(k,s), localparam for L derivation.
- Sub-module ntt_ctrl_delay: parameterised depth/width valid+data shift register with async active-low clear. Instantiated once for {rd_en, rd_addr_top, rd_addr_bot}.

Test Plan:
- LOG_N=3, PE_LAT=2, start pulse, stall=0 -> stage0 (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3; stage1 (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; stage2 (0,1)(2,3)(4,5)(6,7) tw 0; busy 21 cycles, then done for one cycle.
- Same config -> each wr_en/wr_addr pair matches its rd pair exactly 3 cycles later; no wr_en outside the busy window.
- stall=1 for 2 cycles at stage1 k=1 -> rd (1,3) held; rd_en low 2 cycles; matching 2-cycle wr_en bubble; busy 23 cycles.
- start asserted again at busy cycle 5 -> ignored; sequence and done timing unchanged.
- reset low at stage1 k=2 -> all outputs 0 asynchronously; after release no wr_en; a new start produces a full fresh sequence from stage0 k=0.
- NTT_STAGE_CTRL_CYCCNT_EN defined, LOG_N=4, PE_LAT=0 -> cyc_cnt=4*(8+1)=36 at done and holds.
